// File: rtl/slib_fifo_pkg.sv
// Shared constants and helpers for the slib_fifo_flex FIFO family.
package slib_fifo_pkg;
    localparam int SLIB_FIFO_STD  = 0;
    localparam int SLIB_FIFO_FWFT = 1;

    function automatic int usage_w(input int depth_e);
        return depth_e + 1;
    endfunction
endpackage

// File: rtl/slib_fifo_flex_if.sv
// FIFO data/status bundle; master is the user side, slave is the FIFO.
interface slib_fifo_flex_if #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_E = 4
);
    logic               CLEAR;
    logic               WRITE;
    logic               READ;
    logic [WIDTH-1:0]   D;
    logic [WIDTH-1:0]   Q;
    logic               EMPTY;
    logic               FULL;
    logic [DEPTH_E:0]   AF_LEVEL;
    logic [DEPTH_E:0]   AE_LEVEL;
    logic               AFULL;
    logic               AEMPTY;
    logic [DEPTH_E:0]   USAGE;
    logic               OVERFLOW;
    logic               UNDERFLOW;

    modport master (
        output CLEAR, WRITE, READ, D, AF_LEVEL, AE_LEVEL,
        input  Q, EMPTY, FULL, AFULL, AEMPTY, USAGE, OVERFLOW, UNDERFLOW
    );
    modport slave (
        input  CLEAR, WRITE, READ, D, AF_LEVEL, AE_LEVEL,
        output Q, EMPTY, FULL, AFULL, AEMPTY, USAGE, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/slib_fifo_mem.sv
// Simple dual-port RAM, WIDTH x 2**DEPTH_E, synchronous write and registered read.
module slib_fifo_mem #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_E = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               we,
    input  logic [DEPTH_E-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               re,
    input  logic [DEPTH_E-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);
    logic [WIDTH-1:0] mem [2**DEPTH_E];

    // Array left unreset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge CLK) begin
        if (RST)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/slib_fifo_flex.sv
// Synchronous FIFO, standard or FWFT read mode, with registered level status.
// Optional sticky error flags enabled by macro SLIB_FIFO_ERR_FLAGS_EN.
module slib_fifo_flex
    import slib_fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH_E = 4,
    parameter int FWFT    = 0
) (
    input  logic              CLK,
    input  logic              RST,
    slib_fifo_flex_if.slave   bus
);
    localparam int UW    = usage_w(DEPTH_E);
    localparam int DEPTH = 2**DEPTH_E;

    logic [UW-1:0]    wr_ptr, rd_ptr, usage, usage_nxt;
    logic             wr_acc, rd_acc, ram_we, ram_re;
    logic             empty, full, afull, aempty;
    logic [WIDTH-1:0] ram_q;

    assign wr_acc = bus.WRITE && !full;
    assign rd_acc = bus.READ && !empty;

    slib_fifo_mem #(.WIDTH(WIDTH), .DEPTH_E(DEPTH_E)) u_mem (
        .CLK   (CLK),
        .RST   (RST),
        .we    (ram_we),
        .waddr (wr_ptr[DEPTH_E-1:0]),
        .wdata (bus.D),
        .re    (ram_re),
        .raddr (rd_ptr[DEPTH_E-1:0]),
        .rdata (ram_q)
    );

    generate
        if (FWFT == SLIB_FIFO_FWFT) begin : g_fwft
            logic [UW-1:0]    ram_cnt;
            logic             load, q_vld, byp_sel;
            logic [WIDTH-1:0] byp_q;

            // The head stage refills whenever it is vacant or being popped; a
            // write into an otherwise empty FIFO goes straight to the head.
            assign ram_cnt = wr_ptr - rd_ptr;
            assign load    = !q_vld || rd_acc;
            assign ram_re  = !bus.CLEAR && load && (ram_cnt != '0);
            assign ram_we  = !bus.CLEAR && wr_acc && !(load && ram_cnt == '0);
            assign bus.Q   = byp_sel ? byp_q : ram_q;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    q_vld   <= 1'b0;
                    byp_sel <= 1'b0;
                    byp_q   <= '0;
                end else if (bus.CLEAR) begin
                    q_vld   <= 1'b0;
                end else if (load) begin
                    if (ram_cnt != '0) begin
                        q_vld   <= 1'b1;
                        byp_sel <= 1'b0;
                    end else if (wr_acc) begin
                        q_vld   <= 1'b1;
                        byp_sel <= 1'b1;
                        byp_q   <= bus.D;
                    end else begin
                        q_vld   <= 1'b0;
                    end
                end
            end
        end else begin : g_std
            assign ram_re = !bus.CLEAR && rd_acc;
            assign ram_we = !bus.CLEAR && wr_acc;
            assign bus.Q  = ram_q;
        end
    endgenerate

    always_comb begin
        usage_nxt = usage + {{(UW-1){1'b0}}, wr_acc} - {{(UW-1){1'b0}}, rd_acc};
        if (RST || bus.CLEAR) usage_nxt = '0;
    end

    always_ff @(posedge CLK) begin
        if (RST || bus.CLEAR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (ram_we) wr_ptr <= wr_ptr + 1'b1;
            if (ram_re) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Status is derived from the next occupancy so it lands with the operation.
    always_ff @(posedge CLK) begin
        usage  <= usage_nxt;
        empty  <= (usage_nxt == '0);
        full   <= (usage_nxt == UW'(DEPTH));
        afull  <= (usage_nxt >= bus.AF_LEVEL);
        aempty <= (usage_nxt <= bus.AE_LEVEL);
    end

    assign bus.USAGE  = usage;
    assign bus.EMPTY  = empty;
    assign bus.FULL   = full;
    assign bus.AFULL  = afull;
    assign bus.AEMPTY = aempty;

`ifdef SLIB_FIFO_ERR_FLAGS_EN
    logic ovf, unf;
    always_ff @(posedge CLK) begin
        if (RST || bus.CLEAR) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf | (bus.WRITE && full);
            unf <= unf | (bus.READ && empty);
        end
    end
    assign bus.OVERFLOW  = ovf;
    assign bus.UNDERFLOW = unf;
`else
    assign bus.OVERFLOW  = 1'b0;
    assign bus.UNDERFLOW = 1'b0;
`endif
endmodule
